// File: rtl/icache_pkg.sv
// ============================================================================
// Module      : icache_pkg
// Description : Shared types and constants for the direct-mapped icache:
//               FSM state encoding, default geometry and a zero word.
//               Optional feature macro used by the cache: ICACHE_STAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_pkg;

  // Default geometry: 128 one-word lines over a 32-bit byte address space
  localparam int INDEX_W_DEF = 7;
  localparam int ADDR_W_DEF  = 32;

  localparam logic [31:0] ZERO32 = 32'h0000_0000;

  // Cache controller states
  typedef enum logic [0:0] {
    ICACHE_IDLE = 1'b0,
    ICACHE_MISS = 1'b1
  } icache_state_e;

endpackage : icache_pkg

`default_nettype wire

// File: rtl/icache_array.sv
// ============================================================================
// Module      : icache_array
// Description : Valid/tag/data storage for the direct-mapped icache.
//               Combinational read by index, synchronous write port,
//               valid bits cleared synchronously by reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int TAG_W   = ADDR_W_DEF - INDEX_W_DEF - 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [INDEX_W-1:0] rd_idx_i,
  output logic               rd_valid_o,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic [31:0]        rd_data_o,
  input  logic               we_i,
  input  logic [INDEX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic [31:0]        wr_data_i
);

  localparam int ENTRIES = 2 ** INDEX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q  [ENTRIES];
  logic [31:0]        data_q [ENTRIES];

  // Valid bits: cleared by reset, set when a line is filled
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data storage: written on fill only, contents meaningless until valid
  always_ff @(posedge clk_in) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule : icache_array

`default_nettype wire

// File: rtl/icache.sv
// ============================================================================
// Module      : icache
// Description : Direct-mapped instruction cache between the IF stage and the
//               memory controller. One 32-bit instruction per line. Hits
//               return one cycle after the request; misses fetch one word
//               from the controller and return it on the fill edge. Flush
//               cancels any request in flight.
//               Optional: define ICACHE_STAT_EN for saturating hit/miss
//               counters on hitCnt_out / missCnt_out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache
  import icache_pkg::*;
#(
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              IFreq_in,
  input  logic [ADDR_W-1:0] IFpc_in,
  input  logic              flush_in,
  output logic              IFinstE_out,
  output logic [31:0]       IFinst_out,
  output logic              busy_out,
  output logic              memIF_out,
  output logic [ADDR_W-1:0] memAddr_out,
  input  logic              memInstE_in,
  input  logic [31:0]       memInst_in
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0]       hitCnt_out,
  output logic [31:0]       missCnt_out
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W - 2;

  icache_state_e     state_q, state_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [31:0]       inst_q, inst_d;
  logic              instE_q, instE_d;
  logic              fill_we;
  logic              hit_ev;
  logic              miss_ev;

  logic [INDEX_W-1:0] pc_idx;
  logic [TAG_W-1:0]   pc_tag;
  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [31:0]        rd_data;
  logic               unused_pc_lsb;

  assign pc_idx        = IFpc_in[INDEX_W+1:2];
  assign pc_tag        = IFpc_in[ADDR_W-1:INDEX_W+2];
  assign unused_pc_lsb = ^IFpc_in[1:0];

  // Fill address comes from the latched miss address, so IF may change its
  // PC during a miss without corrupting the fill. Reset blocks a pending fill.
  icache_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rd_idx_i   (pc_idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .we_i       (fill_we & ~rst_in),
    .wr_idx_i   (memAddr_q[INDEX_W+1:2]),
    .wr_tag_i   (memAddr_q[ADDR_W-1:INDEX_W+2]),
    .wr_data_i  (memInst_in)
  );

  // Next-state and next-output logic; flush outranks every other event
  always_comb begin
    state_d   = state_q;
    memAddr_d = memAddr_q;
    inst_d    = inst_q;
    instE_d   = 1'b0;
    fill_we   = 1'b0;
    hit_ev    = 1'b0;
    miss_ev   = 1'b0;
    case (state_q)
      ICACHE_IDLE: begin
        if (IFreq_in && !flush_in) begin
          if (rd_valid && (rd_tag == pc_tag)) begin
            instE_d = 1'b1;
            inst_d  = rd_data;
            hit_ev  = 1'b1;
          end else begin
            state_d   = ICACHE_MISS;
            memAddr_d = {IFpc_in[ADDR_W-1:2], 2'b00};
            miss_ev   = 1'b1;
          end
        end
      end
      ICACHE_MISS: begin
        if (flush_in) begin
          state_d = ICACHE_IDLE;
        end else if (memInstE_in) begin
          fill_we = 1'b1;
          inst_d  = memInst_in;
          instE_d = 1'b1;
          state_d = ICACHE_IDLE;
        end
      end
      default: begin
        state_d = ICACHE_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= ICACHE_IDLE;
      memAddr_q <= '0;
      inst_q    <= ZERO32;
      instE_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      memAddr_q <= memAddr_d;
      inst_q    <= inst_d;
      instE_q   <= instE_d;
    end
  end

  assign IFinstE_out = instE_q;
  assign IFinst_out  = inst_q;
  assign busy_out    = (state_q == ICACHE_MISS);
  assign memAddr_out = memAddr_q;
  // Combinational so the controller never sees a request after completion
  // or in the cycle the miss is cancelled
  assign memIF_out   = (state_q == ICACHE_MISS) && !memInstE_in && !flush_in;

`ifdef ICACHE_STAT_EN
  logic [31:0] hitCnt_q;
  logic [31:0] missCnt_q;

  // Saturating hit/miss counters
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hitCnt_q  <= ZERO32;
      missCnt_q <= ZERO32;
    end else begin
      if (hit_ev && (hitCnt_q != 32'hFFFF_FFFF)) begin
        hitCnt_q <= hitCnt_q + 32'd1;
      end
      if (miss_ev && (missCnt_q != 32'hFFFF_FFFF)) begin
        missCnt_q <= missCnt_q + 32'd1;
      end
    end
  end

  assign hitCnt_out  = hitCnt_q;
  assign missCnt_out = missCnt_q;
`else
  logic unused_stat;
  assign unused_stat = hit_ev ^ miss_ev;
`endif

endmodule : icache

`default_nettype wire
